// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath defaults, ALU opcodes, decoded control bundle.
package cpu_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_PC_W = 5;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_SLL   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_SLT   = 5'd8;
  localparam logic [4:0] ALU_SLTU  = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;

  // Control carried through ID/EX alongside the operands.
  typedef struct packed {
    logic       reg_wrenable;
    logic       mem_wrenable;
    logic       mem_to_reg;
    logic       alu_src;
    logic       is_jump;
    logic [4:0] alu_op;
  } ctrl_t;

  // Bubble: nothing written to registers or memory.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/alu.sv
// Combinational ALU; unknown opcodes produce zero.
module alu import cpu_pkg::*; #(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      op,
  output logic [XLEN-1:0] y
);

  // Opcode decode; all arithmetic wraps at XLEN bits.
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SLL:   y = a << b[4:0];
      ALU_SRL:   y = a >> b[4:0];
      ALU_SRA:   y = $signed(a) >>> b[4:0];
      ALU_SLT:   y = XLEN'($signed(a) < $signed(b));
      ALU_SLTU:  y = XLEN'(a < b);
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage: ID/EX register, MEM/WB forwarding, ALU, EX/MEM register,
// and load-use stall generation back to decode.
module execute_stage import cpu_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int PC_W = DEF_PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] id_read_data1,
  input  logic [XLEN-1:0] id_read_data2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_write_reg,
  input  logic            id_reg_wrenable,
  input  logic            id_mem_wrenable,
  input  logic            id_mem_to_reg,
  input  logic            id_alu_src,
  input  logic            id_is_jump,
  input  logic [4:0]      id_alu_op,
  input  logic [PC_W-1:0] id_pc,
  input  logic [4:0]      wb_write_reg,
  input  logic [XLEN-1:0] wb_data,
  input  logic            wb_reg_wrenable,
  output logic            should_stall,
  output logic [XLEN-1:0] ex_result,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_write_reg,
  output logic            ex_reg_wrenable,
  output logic            ex_mem_wrenable,
  output logic            ex_mem_to_reg
);

  ctrl_t           id_ctrl, ctrl_q;
  logic [XLEN-1:0] rd1_q, rd2_q, imm_q;
  logic [4:0]      rs1_q, rs2_q, wr_q;
  logic [PC_W-1:0] pc_q, pc_inc;

  assign id_ctrl = '{reg_wrenable: id_reg_wrenable, mem_wrenable: id_mem_wrenable,
                     mem_to_reg: id_mem_to_reg, alu_src: id_alu_src,
                     is_jump: id_is_jump, alu_op: id_alu_op};

  // A load in EX whose destination feeds the decoding instruction cannot be
  // forwarded in time; hold decode one cycle. The bubble clears the condition.
  assign should_stall = ctrl_q.mem_to_reg & ctrl_q.reg_wrenable & (wr_q != '0) &
                        ((wr_q == id_rs1) | (wr_q == id_rs2));

  // ID/EX register; a stall captures an all-zero bubble instead of decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || should_stall) begin
      ctrl_q <= CTRL_NOP;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      wr_q   <= '0;
      pc_q   <= '0;
    end else begin
      ctrl_q <= id_ctrl;
      rd1_q  <= id_read_data1;
      rd2_q  <= id_read_data2;
      imm_q  <= id_imm;
      rs1_q  <= id_rs1;
      rs2_q  <= id_rs2;
      wr_q   <= id_write_reg;
      pc_q   <= id_pc;
    end
  end

  // Forwarding per operand (0 = A/rs1, 1 = B/rs2). EX/MEM holds the younger
  // value so it wins; loads are never taken from EX/MEM, and x0 never forwards.
  logic [1:0][4:0]      src_rs;
  logic [1:0][XLEN-1:0] src_q, fwd;
  logic                 ex_fwd_ok, wb_fwd_ok;

  assign ex_fwd_ok = ex_reg_wrenable & ~ex_mem_to_reg & (ex_write_reg != '0);
  assign wb_fwd_ok = wb_reg_wrenable & (wb_write_reg != '0);
  assign src_rs    = {rs2_q, rs1_q};
  assign src_q     = {rd2_q, rd1_q};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    assign fwd[i] = (ex_fwd_ok && ex_write_reg == src_rs[i]) ? ex_result :
                    (wb_fwd_ok && wb_write_reg == src_rs[i]) ? wb_data : src_q[i];
  end

  logic [XLEN-1:0] alu_b, alu_y;

  assign alu_b  = ctrl_q.alu_src ? imm_q : fwd[1];
  assign pc_inc = pc_q + PC_W'(1);

  alu #(.XLEN(XLEN)) u_alu (
    .a  (fwd[0]),
    .b  (alu_b),
    .op (ctrl_q.alu_op),
    .y  (alu_y)
  );

  // EX/MEM register; jumps carry the link address instead of the ALU result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_result       <= '0;
      ex_store_data   <= '0;
      ex_write_reg    <= '0;
      ex_reg_wrenable <= 1'b0;
      ex_mem_wrenable <= 1'b0;
      ex_mem_to_reg   <= 1'b0;
    end else begin
      ex_result       <= ctrl_q.is_jump ? {{(XLEN-PC_W){1'b0}}, pc_inc} : alu_y;
      ex_store_data   <= fwd[1];
      ex_write_reg    <= wr_q;
      ex_reg_wrenable <= ctrl_q.reg_wrenable;
      ex_mem_wrenable <= ctrl_q.mem_wrenable;
      ex_mem_to_reg   <= ctrl_q.mem_to_reg;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: the bench plays decode, regfile, MEM and WB around
// the DUT and predicts every output from in-order architectural execution.
module tb_execute_stage;
  import cpu_pkg::*;

  logic        clk, rst_n;
  logic [31:0] id_read_data1, id_read_data2, id_imm, wb_data;
  logic [4:0]  id_rs1, id_rs2, id_write_reg, id_alu_op, id_pc, wb_write_reg;
  logic        id_reg_wrenable, id_mem_wrenable, id_mem_to_reg, id_alu_src, id_is_jump;
  logic        wb_reg_wrenable, should_stall;
  logic [31:0] ex_result, ex_store_data;
  logic [4:0]  ex_write_reg;
  logic        ex_reg_wrenable, ex_mem_wrenable, ex_mem_to_reg;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_write_reg(id_write_reg),
    .id_reg_wrenable(id_reg_wrenable), .id_mem_wrenable(id_mem_wrenable),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_is_jump(id_is_jump),
    .id_alu_op(id_alu_op), .id_pc(id_pc),
    .wb_write_reg(wb_write_reg), .wb_data(wb_data), .wb_reg_wrenable(wb_reg_wrenable),
    .should_stall(should_stall), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_reg_wrenable(ex_reg_wrenable),
    .ex_mem_wrenable(ex_mem_wrenable), .ex_mem_to_reg(ex_mem_to_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op, rd, rs1, rs2, pc;
    logic [31:0] imm, ldval;
    logic        src, we, mwe, ld, jmp;
  } ins_t;

  // What an accepted instruction must show on the ex_* outputs, plus the value it retires.
  typedef struct packed {
    logic [31:0] res, sd, wbval;
    logic [4:0]  wr;
    logic        we, mwe, m2r;
  } exp_t;

  logic [31:0] rf   [32];  // committed register file (written at WB)
  logic [31:0] arch [32];  // in-order architectural state
  exp_t ex_slot, mem_slot, wb_slot;
  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s = b % 32;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << s;
      6: return a >> s;
      7: return a[31] ? ~((~a) >> s) : a >> s;
      8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      9: return (a < b) ? 32'd1 : 32'd0;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic ins_t mk(input logic [4:0] op, rd, rs1, rs2, input logic [31:0] imm,
                              input logic src, we);
    ins_t i;
    i = '0;
    i.op = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm; i.src = src; i.we = we;
    return i;
  endfunction

  function automatic ins_t mk_load(input logic [4:0] rd, input logic [31:0] v);
    ins_t i;
    i = mk(ALU_ADD, rd, 5'd0, 5'd0, 32'h100, 1'b1, 1'b1);
    i.ld = 1'b1; i.ldval = v;
    return i;
  endfunction

  function automatic ins_t mk_jump(input logic [4:0] rd, input logic [4:0] pc);
    ins_t i;
    i = mk(ALU_ADD, rd, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
    i.jmp = 1'b1; i.pc = pc;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    int k;
    i = '0;
    k = $urandom_range(0, 9);
    i.op = 5'($urandom_range(0, 12));
    i.rd = 5'($urandom_range(0, 7)); i.rs1 = 5'($urandom_range(0, 7)); i.rs2 = 5'($urandom_range(0, 7));
    i.imm = $urandom; i.ldval = $urandom; i.pc = 5'($urandom);
    if (k <= 3) i.we = (k != 3);
    else if (k <= 5) begin i.src = 1'b1; i.we = 1'b1; end
    else if (k <= 7) begin i.op = ALU_ADD; i.src = 1'b1; i.we = 1'b1; i.ld = 1'b1; end
    else if (k == 8) begin i.op = ALU_ADD; i.src = 1'b1; i.mwe = 1'b1; end
    else begin i.we = 1'b1; i.jmp = 1'b1; end
    return i;
  endfunction

  // Regfile read with write-through of the value retiring this cycle.
  function automatic logic [31:0] rf_rd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_slot.we && wb_slot.wr == r) return wb_slot.wbval;
    return rf[r];
  endfunction

  task automatic drive(input ins_t in);
    wb_reg_wrenable = wb_slot.we; wb_write_reg = wb_slot.wr; wb_data = wb_slot.wbval;
    id_read_data1 = rf_rd(in.rs1); id_read_data2 = rf_rd(in.rs2); id_imm = in.imm;
    id_rs1 = in.rs1; id_rs2 = in.rs2; id_write_reg = in.rd; id_alu_op = in.op; id_pc = in.pc;
    id_reg_wrenable = in.we; id_mem_wrenable = in.mwe; id_mem_to_reg = in.ld;
    id_alu_src = in.src; id_is_jump = in.jmp;
  endtask

  task automatic chk_ex(input string p);
    chk({p, ".result"}, ex_result, mem_slot.res);
    chk({p, ".store_data"}, ex_store_data, mem_slot.sd);
    chk({p, ".write_reg"}, 32'(ex_write_reg), 32'(mem_slot.wr));
    chk({p, ".reg_we"}, 32'(ex_reg_wrenable), 32'(mem_slot.we));
    chk({p, ".mem_we"}, 32'(ex_mem_wrenable), 32'(mem_slot.mwe));
    chk({p, ".mem_to_reg"}, 32'(ex_mem_to_reg), 32'(mem_slot.m2r));
  endtask

  // One clock: present `in`, check the stall, advance the model pipeline, check ex_*.
  task automatic step(input ins_t in, output logic acc);
    exp_t e;
    logic [31:0] a, b;
    logic exp_stall;
    drive(in);
    #1;
    exp_stall = ex_slot.m2r && ex_slot.we && ex_slot.wr != 5'd0 &&
                (ex_slot.wr == in.rs1 || ex_slot.wr == in.rs2);
    chk("should_stall", 32'(should_stall), 32'(exp_stall));
    acc = !exp_stall;
    e = '0;
    if (acc) begin
      a = arch[in.rs1]; b = arch[in.rs2];
      e.res = in.jmp ? 32'((int'(in.pc) + 1) % 32) : ref_alu(in.op, a, in.src ? in.imm : b);
      e.sd = b; e.wr = in.rd; e.we = in.we; e.mwe = in.mwe; e.m2r = in.ld;
      e.wbval = in.ld ? in.ldval : e.res;
      if (in.we && in.rd != 5'd0) arch[in.rd] = e.wbval;
    end
    @(posedge clk);
    if (wb_slot.we && wb_slot.wr != 5'd0) rf[wb_slot.wr] = wb_slot.wbval;
    wb_slot = mem_slot; mem_slot = ex_slot; ex_slot = e;
    #1;
    chk_ex("ex");
  endtask

  task automatic issue(input ins_t in, output int ns);
    logic acc;
    acc = 1'b0;
    ns = 0;
    for (int t = 0; t < 4 && !acc; t++) begin
      step(in, acc);
      if (!acc) ns++;
    end
    chk("issue.accepted", 32'(acc), 32'd1);
  endtask

  ins_t NOP;

  initial begin
    int ns;
    NOP = mk(ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    for (int r = 0; r < 32; r++) rf[r] = 32'd0;
    rf[10] = 32'd5; rf[11] = 32'd7; rf[12] = 32'h8000_0000; rf[15] = 32'hFFFF_FFFF;
    arch = rf;
    ex_slot = '0; mem_slot = '0; wb_slot = '0;

    // Reset state
    rst_n = 1'b0;
    drive(NOP);
    repeat (2) @(posedge clk);
    #1;
    chk_ex("reset");
    chk("reset.stall", 32'(should_stall), 32'd0);
    #3 rst_n = 1'b1;

    // EX/MEM forward over a stale regfile
    issue(mk(ALU_ADD, 5'd1, 5'd10, 5'd11, 32'd0, 1'b0, 1'b1), ns);
    issue(mk(ALU_SUB, 5'd2, 5'd1, 5'd0, 32'd2, 1'b1, 1'b1), ns);
    chk("exfwd.nostall", 32'(ns), 32'd0);
    chk("exfwd.add", ex_result, 32'd12);
    issue(NOP, ns);
    chk("exfwd.sub", ex_result, 32'd10);

    // EX/MEM beats WB on the same register, then WB alone
    issue(mk(ALU_ADD, 5'd3, 5'd0, 5'd0, 32'd1, 1'b1, 1'b1), ns);
    issue(mk(ALU_ADD, 5'd3, 5'd0, 5'd0, 32'd9, 1'b1, 1'b1), ns);
    issue(mk(ALU_ADD, 5'd6, 5'd3, 5'd0, 32'd0, 1'b0, 1'b1), ns);
    issue(NOP, ns);
    chk("prio.ex_wins", ex_result, 32'd9);
    issue(mk(ALU_ADD, 5'd3, 5'd0, 5'd0, 32'd1, 1'b1, 1'b1), ns);
    issue(mk(ALU_ADD, 5'd8, 5'd0, 5'd0, 32'd0, 1'b1, 1'b1), ns);
    issue(mk(ALU_ADD, 5'd6, 5'd3, 5'd0, 32'd0, 1'b0, 1'b1), ns);
    issue(NOP, ns);
    chk("prio.wb_only", ex_result, 32'd1);

    // Load-use: one stall, bubble, then the WB path supplies the load data
    issue(mk_load(5'd4, 32'h20), ns);
    issue(mk(ALU_ADD, 5'd5, 5'd4, 5'd0, 32'd1, 1'b1, 1'b1), ns);
    chk("loaduse.stall_cycles", 32'(ns), 32'd1);
    chk("loaduse.bubble_we", 32'(ex_reg_wrenable), 32'd0);
    issue(NOP, ns);
    chk("loaduse.result", ex_result, 32'h21);

    // x0 is never forwarded and never stalls
    issue(mk(ALU_ADD, 5'd0, 5'd0, 5'd0, 32'hFF, 1'b1, 1'b1), ns);
    issue(mk(ALU_ADD, 5'd9, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1), ns);
    chk("x0.alu_nostall", 32'(ns), 32'd0);
    issue(NOP, ns);
    chk("x0.alu_operand", ex_result, 32'd0);
    issue(mk_load(5'd0, 32'hAB), ns);
    issue(mk(ALU_ADD, 5'd9, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1), ns);
    chk("x0.load_nostall", 32'(ns), 32'd0);
    issue(NOP, ns);
    chk("x0.load_operand", ex_result, 32'd0);

    // ALU corner cases and link wrap
    issue(mk(ALU_SRA, 5'd13, 5'd12, 5'd0, 32'd31, 1'b1, 1'b1), ns);
    issue(mk(ALU_SLT, 5'd16, 5'd15, 5'd0, 32'd1, 1'b1, 1'b1), ns);
    chk("alu.sra", ex_result, 32'hFFFF_FFFF);
    issue(mk(ALU_SLTU, 5'd17, 5'd15, 5'd0, 32'd1, 1'b1, 1'b1), ns);
    chk("alu.slt", ex_result, 32'd1);
    issue(mk_jump(5'd1, 5'd31), ns);
    chk("alu.sltu", ex_result, 32'd0);
    issue(mk_jump(5'd1, 5'd6), ns);
    chk("jump.wrap", ex_result, 32'd0);
    issue(NOP, ns);
    chk("jump.link", ex_result, 32'd7);

    // Random stream against the architectural model
    for (int n = 0; n < 300; n++) issue(rnd_ins(), ns);

    // Asynchronous reset mid-stream with a pending load-use hazard
    issue(mk(ALU_ADD, 5'd22, 5'd0, 5'd0, 32'h55, 1'b1, 1'b1), ns);
    issue(mk_load(5'd20, 32'h1234), ns);
    drive(mk(ALU_ADD, 5'd21, 5'd20, 5'd0, 32'd0, 1'b0, 1'b1));
    #1;
    chk("rst.pre_stall", 32'(should_stall), 32'd1);
    chk("rst.pre_result", ex_result, 32'h55);
    rst_n = 1'b0;
    #1;
    chk("rst.async_stall", 32'(should_stall), 32'd0);
    chk("rst.async_result", ex_result, 32'd0);
    chk("rst.async_write_reg", 32'(ex_write_reg), 32'd0);
    chk("rst.async_reg_we", 32'(ex_reg_wrenable), 32'd0);
    chk("rst.async_mem_to_reg", 32'(ex_mem_to_reg), 32'd0);
    ex_slot = '0; mem_slot = '0; wb_slot = '0;
    arch = rf;
    drive(NOP);
    @(posedge clk);
    #1;
    chk_ex("rst.hold");
    #3 rst_n = 1'b1;
    issue(mk(ALU_ADD, 5'd23, 5'd0, 5'd0, 32'd7, 1'b1, 1'b1), ns);
    chk("rst.first_edge_we", 32'(ex_reg_wrenable), 32'd0);
    issue(NOP, ns);
    chk("rst.second_edge_result", ex_result, 32'd7);
    repeat (3) issue(NOP, ns);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
